// File: rtl/spi_key_scheduler.sv
// Key-event scheduler: buffers scanner key codes in a small FIFO and hands them to
// the SPI interface one at a time with a term strobe, retrying when no ack arrives.
module spi_key_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                     clk,
  input  logic                     rst_bar,
  input  logic                     key_valid,
  input  logic [3:0]               key_in,
  input  logic                     busy,
  input  logic                     clr_err,
  output logic [3:0]               key_code,
  output logic                     term,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     drop_err
);

  localparam int unsigned KW = 4;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  // The timeout counter only ever holds 0..ACK_TIMEOUT-1.
  localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   mem_q [DEPTH];
  logic [KW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   key_q, key_d;
  logic [TW-1:0]   to_q, to_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            term_q, term_d;
  logic            ovf_q, ovf_d;
  logic            drop_q, drop_d;
  logic            push, pop, full, drop_set;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      to_q    <= '0;
      retry_q <= '0;
      term_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      to_q    <= to_d;
      retry_q <= retry_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, FIFO bookkeeping and error flags.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    to_d     = to_q;
    retry_d  = retry_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    pop      = 1'b0;
    drop_set = 1'b0;
    full     = (cnt_q == PW'(DEPTH));

    case (state_q)
      IDLE: begin
        if ((cnt_q != '0) && !busy) begin
          pop     = 1'b1;
          key_d   = mem_q[rd_q];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        to_d    = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (busy) begin
          retry_d = '0;
          state_d = WAIT_DONE;
        end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            drop_set = 1'b1;
            retry_d  = '0;
            state_d  = IDLE;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = ISSUE;
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    push = key_valid && (!full || pop);
    if (push) begin
      mem_d[wr_q] = key_in;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (key_valid && !push) ovf_d = 1'b1;
    else if (clr_err)       ovf_d = 1'b0;
    if (drop_set)           drop_d = 1'b1;
    else if (clr_err)       drop_d = 1'b0;

    term_d = (state_d == ISSUE);
  end

  assign key_code = key_q;
  assign term     = term_q;
  assign pending  = cnt_q;
  assign overflow = ovf_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_spi_key_scheduler.sv
// Directed bench for spi_key_scheduler: cycle tables for burst/overflow plus
// hand sequences for single key, timeout/retry and asynchronous reset.
module tb_spi_key_scheduler;

  logic       clk = 1'b0;
  logic       rst_bar;
  logic       key_valid, busy, clr_err;
  logic [3:0] key_in;
  logic [3:0] key_code;
  logic       term, overflow, drop_err;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tcyc[$];
  logic [3:0] tcode[$];

  typedef struct {
    logic       kv;
    logic [3:0] k;
    logic       b;
    logic       ce;
    logic [9:0] exp;  // {term, key_code, pending, overflow, drop_err}
  } vec_t;

  vec_t tbl[$];

  spi_key_scheduler #(.DEPTH(4), .ACK_TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_bar(rst_bar), .key_valid(key_valid), .key_in(key_in),
    .busy(busy), .clr_err(clr_err), .key_code(key_code), .term(term),
    .pending(pending), .overflow(overflow), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Log every term pulse with the cycle it was seen and the code it carried.
  always @(posedge clk) begin
    if (term) begin
      tcyc.push_back(cyc);
      tcode.push_back(key_code);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] k, input logic b, input logic ce);
    key_valid = kv;
    key_in    = k;
    busy      = b;
    clr_err   = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic kv, input logic [3:0] k, input logic b, input logic ce,
                     input logic t, input logic [3:0] kc, input logic [2:0] p,
                     input logic o, input logic d);
    vec_t v;
    v.kv = kv; v.k = k; v.b = b; v.ce = ce;
    v.exp = {t, kc, p, o, d};
    tbl.push_back(v);
  endtask

  function automatic logic [9:0] outs();
    return {term, key_code, pending, overflow, drop_err};
  endfunction

  initial begin
    logic seen4;
    rst_bar = 1'b0; key_valid = 1'b0; key_in = '0; busy = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'h0);
    #2 rst_bar = 1'b1;
    @(posedge clk); #1;

    // Single key 7: term two cycles after key_valid, SPI acks 3 cycles later.
    tcyc.delete(); tcode.delete();
    step(1'b1, 4'h7, 1'b0, 1'b0);
    chk("single_no_term_n1", 32'(term), 32'h0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("single_term_n2", 32'({term, key_code}), 32'h17);
    chk("single_pending0", 32'(pending), 32'h0);
    repeat (3)  step(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 4'h0, 1'b1, 1'b0);
    repeat (5)  step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("single_one_term", 32'(tcode.size()), 32'd1);

    // Burst 1..4 under busy, overflow with 9, clear, full push+pop with A, drain.
    add(1, 4'h1, 1, 0,  0, 4'h7, 3'd1, 0, 0);
    add(1, 4'h2, 1, 0,  0, 4'h7, 3'd2, 0, 0);
    add(1, 4'h3, 1, 0,  0, 4'h7, 3'd3, 0, 0);
    add(1, 4'h4, 1, 0,  0, 4'h7, 3'd4, 0, 0);
    add(1, 4'h9, 1, 0,  0, 4'h7, 3'd4, 1, 0);
    add(0, 4'h0, 1, 1,  0, 4'h7, 3'd4, 0, 0);
    add(1, 4'hA, 0, 0,  1, 4'h1, 3'd4, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'h1, 3'd4, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h1, 3'd4, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'h1, 3'd4, 0, 0);
    add(0, 4'h0, 0, 0,  1, 4'h2, 3'd3, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h2, 3'd3, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h2, 3'd3, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'h2, 3'd3, 0, 0);
    add(0, 4'h0, 0, 0,  1, 4'h3, 3'd2, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h3, 3'd2, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h3, 3'd2, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'h3, 3'd2, 0, 0);
    add(0, 4'h0, 0, 0,  1, 4'h4, 3'd1, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h4, 3'd1, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'h4, 3'd1, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'h4, 3'd1, 0, 0);
    add(0, 4'h0, 0, 0,  1, 4'hA, 3'd0, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'hA, 3'd0, 0, 0);
    add(0, 4'h0, 1, 0,  0, 4'hA, 3'd0, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'hA, 3'd0, 0, 0);
    add(0, 4'h0, 0, 0,  0, 4'hA, 3'd0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].kv, tbl[i].k, tbl[i].b, tbl[i].ce);
      chk($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Timeout/retry: B is never acked, issued 4 times then dropped; C follows.
    tcyc.delete(); tcode.delete();
    seen4 = 1'b0;
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    for (int i = 0; i < 80 && tcode.size() < 5; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      if (tcode.size() == 4 && !seen4) begin
        seen4 = 1'b1;
        chk("no_drop_before_last_retry", 32'(drop_err), 32'h0);
      end
    end
    chk("retry_term_count", 32'(tcode.size()), 32'd5);
    if (tcode.size() == 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("retry_code%0d", i), 32'(tcode[i]), 32'hB);
      for (int i = 1; i < 4; i++) chk($sformatf("retry_gap%0d", i), 32'(tcyc[i] - tcyc[i-1]), 32'd9);
      chk("next_key_after_drop", 32'(tcode[4]), 32'hC);
    end
    chk("drop_err_set", 32'(drop_err), 32'h1);

    // C acked; while SPI stays busy queue two more keys, then reset mid-transfer.
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h6, 1'b1, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    chk("pre_reset_state", 32'(outs()), 32'({1'b0, 4'hC, 3'd2, 1'b0, 1'b1}));
    #2 rst_bar = 1'b0;
    #1 chk("async_reset_outputs", 32'(outs()), 32'h0);
    @(posedge clk);
    #3 rst_bar = 1'b1;
    busy = 1'b0;
    tcyc.delete(); tcode.delete();
    repeat (10) step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("no_term_after_reset", 32'(tcode.size()), 32'd0);
    chk("flushed_pending", 32'(pending), 32'h0);
    step(1'b1, 4'hE, 1'b0, 1'b0);
    chk("post_reset_no_term_n1", 32'(term), 32'h0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("post_reset_term_n2", 32'({term, key_code}), 32'h1E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
